// File: rtl/serdes_lane_arbiter_pkg.sv
// Shared types, counter width and parameter legality helper for the SerDes lane arbiter.
`default_nettype none

package serdes_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;

  function automatic bit arb_params_ok(input int nreq, input int max_burst, input int idle_timeout);
    return (nreq >= 2) && (nreq <= 8) &&
           (max_burst >= 1) && (max_burst <= 255) &&
           (idle_timeout >= 1) && (idle_timeout <= 255);
  endfunction

  // Saturating increment keeps the burst counters from ever wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serdes_lane_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above start_i, wrapping modulo NREQ.
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   start_i,
  output logic            found_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    int k;
    k       = 0;
    found_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(start_i) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      if (!found_o && req_i[k]) begin
        found_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/serdes_lane_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one SerDes serializer lane between NREQ byte sources.
`default_nettype none

module serdes_lane_arbiter
  import serdes_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DW           = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DW-1:0]       data_i,
  input  logic [NREQ-1:0]          last_i,
  output logic [NREQ-1:0]          ack_o,
  output logic [NREQ-1:0]          gnt_o,
  output logic [DW-1:0]            tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [$clog2(NREQ)-1:0]  tx_id_o,
  output logic                     busy_o
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_XFER = ST_XFER;

  if (!arb_params_ok(NREQ, MAX_BURST, IDLE_TIMEOUT)) begin : g_param_err
    $error("serdes_lane_arbiter: illegal NREQ/MAX_BURST/IDLE_TIMEOUT");
  end

  logic [0:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic             pick_found;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   pick_idx;

  logic             xfer;
  logic             g_req;
  logic             g_last;
  logic [DW-1:0]    g_data;
  logic             beat;
  logic [CNT_W-1:0] idle_inc;
  logic             end_last;
  logic             end_max;
  logic             end_timeout;
  logic             burst_end;
  logic [IDW-1:0]   id_plus1;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IDW)
  ) u_pick (
    .req_i   (req_i),
    .start_i (ptr_q),
    .found_o (pick_found),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  assign xfer   = (state_q == S_XFER);
  assign g_req  = req_i[id_q];
  assign g_last = last_i[id_q];
  assign g_data = data_i[int'(id_q)*DW +: DW];
  assign beat   = xfer & g_req & tx_ready_i;

  // Only a missing request counts towards the timeout; a stalled serializer never does.
  assign idle_inc    = sat_inc(idle_cnt_q);
  assign end_last    = beat & g_last;
  assign end_max     = beat & (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign end_timeout = xfer & ~g_req & (idle_inc >= CNT_W'(IDLE_TIMEOUT));
  assign burst_end   = end_last | end_max | end_timeout;

  assign id_plus1 = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_XFER;
          gnt_d      = pick_gnt;
          id_d       = pick_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      S_XFER: begin
        if (burst_end) begin
          state_d    = S_IDLE;
          gnt_d      = '0;
          id_d       = '0;
          ptr_d      = id_plus1;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end else if (beat) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          idle_cnt_d = '0;
        end else if (!g_req) begin
          idle_cnt_d = idle_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign tx_id_o    = id_q;
  assign busy_o     = xfer;
  assign tx_valid_o = xfer & g_req;
  assign tx_data_o  = xfer ? g_data : '0;
  assign ack_o      = xfer ? (NREQ'(tx_ready_i) << id_q) : '0;

endmodule

`default_nettype wire

// File: tb/tb_serdes_lane_arbiter.sv
// Directed bench for serdes_lane_arbiter (NREQ=4, DW=8, MAX_BURST=4, IDLE_TIMEOUT=8).
`default_nettype none

module tb_serdes_lane_arbiter;

  logic        clk_i;
  logic        rst_n_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  last_i;
  logic [3:0]  ack_o;
  logic [3:0]  gnt_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [1:0]  tx_id_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  serdes_lane_arbiter #(
    .NREQ         (4),
    .DW           (8),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .last_i     (last_i),
    .ack_o      (ack_o),
    .gnt_o      (gnt_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_id_o    (tx_id_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       valid;
    logic [7:0] txd;
    logic [3:0] ack;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rdy, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    req_i      = r;
    last_i     = l;
    tx_ready_i = rdy;
    data_i     = d;
    @(negedge clk_i);
  endtask

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  initial begin
    rst_n_i    = 1'b0;
    req_i      = '0;
    last_i     = '0;
    tx_ready_i = 1'b0;
    data_i     = '0;

    //            req      last     rdy   gnt      id    busy  vld   txd     ack
    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hC2, 4'b0100};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hC2, 4'b0100};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 8'hD3, 4'b0000};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'hD3, 4'b1000};
    tbl[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'hD3, 4'b1000};
    tbl[8]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'hD3, 4'b1000};
    tbl[9]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'hD3, 4'b1000};
    tbl[10] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[11] = '{4'b1111, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0, 4'b0001};
    tbl[12] = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[13] = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0, 4'b0001};

    // Reset state while requests are pending.
    req_i = 4'b1111;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_gnt",   32'(gnt_o), 32'h0);
    chk("reset_busy",  32'(busy_o), 32'h0);
    chk("reset_valid", 32'(tx_valid_o), 32'h0);
    chk("reset_ack",   32'(ack_o), 32'h0);
    chk("reset_txd",   32'(tx_data_o), 32'h0);
    chk("reset_id",    32'(tx_id_o), 32'h0);
    @(posedge clk_i);
    #1;
    req_i   = 4'b0000;
    rst_n_i = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].req, tbl[i].last, tbl[i].ready, 32'hD3C2B1A0);
      chk($sformatf("row%0d_gnt", i),   32'(gnt_o),      32'(tbl[i].gnt));
      chk($sformatf("row%0d_id", i),    32'(tx_id_o),    32'(tbl[i].id));
      chk($sformatf("row%0d_busy", i),  32'(busy_o),     32'(tbl[i].busy));
      chk($sformatf("row%0d_valid", i), 32'(tx_valid_o), 32'(tbl[i].valid));
      chk($sformatf("row%0d_txd", i),   32'(tx_data_o),  32'(tbl[i].txd));
      chk($sformatf("row%0d_ack", i),   32'(ack_o),      32'(tbl[i].ack));
    end

    // Requester 0 holds the lane with one beat done; 7 empty cycles must not time out.
    for (int j = 1; j <= 7; j++) begin
      drive(4'b0100, 4'b0000, 1'b1, 32'hD3C2B1A0);
      chk($sformatf("drop7_busy%0d", j),  32'(busy_o), 32'h1);
      chk($sformatf("drop7_valid%0d", j), 32'(tx_valid_o), 32'h0);
    end
    drive(4'b0001, 4'b0000, 1'b1, 32'hD3C2B1A0);
    chk("resume_busy",  32'(busy_o), 32'h1);
    chk("resume_valid", 32'(tx_valid_o), 32'h1);
    chk("resume_gnt",   32'(gnt_o), 32'h1);

    // Eight empty cycles: lane is released on the eighth edge.
    for (int j = 1; j <= 8; j++) begin
      drive(4'b0100, 4'b0000, 1'b1, 32'hD3C2B1A0);
      chk($sformatf("drop8_busy%0d", j), 32'(busy_o), 32'h1);
    end
    drive(4'b1111, 4'b0000, 1'b0, 32'hEEDD10BB);
    chk("timeout_busy", 32'(busy_o), 32'h0);
    chk("timeout_gnt",  32'(gnt_o), 32'h0);

    // Pointer moved to 1, so requester 1 wins; then 20 stalled cycles.
    for (int j = 0; j < 20; j++) begin
      drive(4'b1111, 4'b0000, 1'b0, 32'hEEDD10BB);
      chk($sformatf("bp%0d_gnt", j), 32'(gnt_o), 32'h2);
      chk($sformatf("bp%0d_ack", j), 32'(ack_o), 32'h0);
      chk($sformatf("bp%0d_txd", j), 32'(tx_data_o), 32'h10);
      chk($sformatf("bp%0d_vld", j), 32'(tx_valid_o), 32'h1);
    end

    // Last flag coincides with the MAX_BURST beat.
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(8'h10 + 8'(b));
      drive(4'b1111, (b == 3) ? 4'b0010 : 4'b0000, 1'b1, {8'hEE, 8'hDD, 8'h10 + 8'(b), 8'hBB});
      chk($sformatf("burst_b%0d_busy", b), 32'(busy_o), 32'h1);
      if (tx_valid_o && tx_ready_i) begin
        got_q.push_back(tx_data_o);
      end
    end
    drive(4'b1111, 4'b0000, 1'b1, 32'hD3C2B1A0);
    chk("simend_busy", 32'(busy_o), 32'h0);
    chk("simend_gnt",  32'(gnt_o), 32'h0);
    chk("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("sb_byte%0d", b),
          (b < got_q.size()) ? 32'(got_q[b]) : 32'hFFFF_FFFF, 32'(exp_q[b]));
    end

    // Single end event: pointer steps from 1 to 2 only.
    drive(4'b1111, 4'b0000, 1'b1, 32'hD3C2B1A0);
    chk("next_gnt",   32'(gnt_o), 32'h4);
    chk("next_id",    32'(tx_id_o), 32'h2);
    chk("next_valid", 32'(tx_valid_o), 32'h1);

    // Asynchronous reset in the middle of a burst.
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("areset_valid", 32'(tx_valid_o), 32'h0);
    chk("areset_gnt",   32'(gnt_o), 32'h0);
    chk("areset_busy",  32'(busy_o), 32'h0);
    chk("areset_ack",   32'(ack_o), 32'h0);
    chk("areset_txd",   32'(tx_data_o), 32'h0);
    chk("areset_id",    32'(tx_id_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("postreset_idle", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    chk("postreset_gnt", 32'(gnt_o), 32'h1);
    chk("postreset_id",  32'(tx_id_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serdes_lane_arbiter.md
# serdes_lane_arbiter

Round-robin arbiter and burst sequencer that shares one SerDes serializer lane between several parallel byte sources. It sits in the parallel-clock domain in front of the SerDes parallel input. It grants one requester at a time and forwards that requester's bytes over a valid/ready handshake. Each grant (burst) ends on the requester's last flag, a beat limit, or an idle timeout.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 8: byte/word width forwarded to the serializer
- MAX_BURST, 4: maximum beats per grant (1..255)
- IDLE_TIMEOUT, 8: consecutive granted-but-not-valid cycles that abort a burst (1..255)
- clk_i  input  1  single clock (parallel clock domain); all logic on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- req_i  input  NREQ  per-requester valid; bit k = requester k has a byte on data_i
- data_i  input  NREQ*DW  packed bytes; requester k occupies bits [k*DW +: DW]
- last_i  input  NREQ  per-requester end-of-burst flag, qualified by the beat
- ack_o  output  NREQ  per-requester ready; bit k high = current byte of k accepted this cycle if req_i[k]
- gnt_o  output  NREQ  one-hot registered grant, 0 when idle
- tx_data_o  output  DW  byte to serializer
- tx_valid_o  output  1  byte valid to serializer
- tx_ready_i  input  1  serializer ready
- tx_id_o  output  $clog2(NREQ)  index of granted requester (0 when idle)
- busy_o  output  1  high while a burst is in progress

## Operation
- States: IDLE, XFER.
- IDLE: if any req_i bit is set, pick the first set bit at or above ptr, wrapping modulo NREQ. Register gnt_o and tx_id_o, clear beat_cnt and idle_cnt, go to XFER. If no request, stay in IDLE.
- XFER, with g = tx_id_o:
  - Combinational outputs: tx_valid_o = req_i[g]; tx_data_o = data_i[g]; ack_o[g] = tx_ready_i; all other ack_o bits 0.
- Beat = tx_valid_o & tx_ready_i. On a beat: beat_cnt+1, idle_cnt cleared.
- Cycle with req_i[g]=0: idle_cnt+1.
  - Granted, valid, but not ready: idle_cnt holds. Backpressure never times out.
- Burst end, checked at the clock edge: beat with last_i[g]=1, OR beat with beat_cnt==MAX_BURST-1, OR idle_cnt reaching IDLE_TIMEOUT.
  - At burst end: go to IDLE, gnt_o=0, tx_id_o=0, ptr = (g+1) mod NREQ.
  - Several end conditions in the same cycle are one end event; ptr advances once.
- Requests from non-granted requesters are ignored during XFER, with ack_o=0. Fairness: every continuously requesting source gets a grant within NREQ bursts.
- req_i[g] may drop and re-rise within a burst without ending it, unless the timeout is hit.
- Counters are 8-bit and saturate, so no wrap is possible within the parameter range.

## Timing
- Reset (async assert, sync release) forces: state IDLE, gnt_o=0, tx_id_o=0, busy_o=0, tx_valid_o=0, tx_data_o=0, ack_o=0, ptr=0, counters 0.
- Reset mid-burst: the partial burst is dropped. tx_valid_o falls immediately with reset assertion. No beat is produced until a new grant.
- Grant latency: request seen in IDLE at edge n, so gnt_o/busy_o are high from cycle n+1. The first beat is possible in cycle n+1.
- Data path: zero-latency combinational from data_i/req_i/tx_ready_i to the tx/ack outputs; no buffering inside the block.
- Bubble: the cycle after burst end is always IDLE. Back-to-back bursts have exactly one dead cycle.
- Outputs in IDLE: tx_valid_o=0 and tx_data_o=0.

## Structure
- Package serdes_arb_pkg holds:
  - state enum (IDLE, XFER)
  - CNT_W=8
  - parameter legality checks: NREQ range, MAX_BURST≥1, IDLE_TIMEOUT≥1
- Sub-module rr_pick: combinational. Takes NREQ-bit request vector plus start pointer; returns found flag, one-hot grant and index. It is instantiated once in IDLE decision logic.
- Top holds FSM, ptr, beat_cnt, idle_cnt, output muxing.

## Test plan
- Reset: assert rst_n_i mid-cycle with req_i=4'b1111 → all outputs 0 asynchronously. After release, first grant is requester 0, gnt_o=4'b0001 one cycle later.
- Round robin: req_i=4'b1111 held, last_i=0, tx_ready_i=1, MAX_BURST=4 → grants 0,1,2,3,0. Each grant has 4 beats followed by a 1-cycle gap.
- Last flag: requester 2 alone, last_i[2] on beat 2 → burst ends after 2 beats; gnt_o=0 the next cycle; ptr=3.
- Backpressure: tx_ready_i=0 for 20 cycles with req_i[g]=1 → no timeout, ack_o[g]=0, tx_data_o stable. The burst continues when ready returns.
- Timeout: granted requester drops req_i for 8 cycles (IDLE_TIMEOUT=8) → IDLE on the 8th edge, ptr advances. Drop for 7 cycles then resume → burst continues.
- Simultaneous end: last_i on beat 4 with MAX_BURST=4 → single end event, ptr advances by exactly one. Data ordering matches a scoreboard per requester.
